matrix_operand_server: RTL and testbench

- Responder and memory side of the sequential matrix multiplier's operand/result interface.
- Holds operand matrices A and B (M x M, 32-bit words) and answers the multiplier's index-addressed reads combinationally.
- Accepts the multiplier's z_out/z_stb result beats with a z_ack handshake and stores them in result matrix R.
- Faces the host through a streaming load port for A and B, a go/start sequencer, and a streaming result drain port.

---
 rtl/matrix_operand_server_pkg.sv | 28 ++
 rtl/matrix_operand_server_regfile.sv | 34 +++
 rtl/matrix_operand_server.sv | 170 +++++++++++++++++
 tb/tb_matrix_operand_server.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_operand_server_pkg.sv
// Shared definitions for the matrix operand server: sequencer state encoding,
// index-width computation and row-major addressing helpers.
package matrix_operand_server_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic int idx_w(input int m);
    int w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int rm_addr(input int i, input int j, input int m);
    return i * m + j;
  endfunction

  function automatic logic idx_ok(input int i, input int j, input int m);
    return (i < m) && (j < m);
  endfunction

endpackage

// File: rtl/matrix_operand_server_regfile.sv
// M*M x 32-bit register file: asynchronous read, one synchronous write port,
// cleared by reset or by a synchronous clear strobe.
module matrix_regfile
  import matrix_operand_server_pkg::*;
#(
  parameter int M  = 4,
  parameter int AW = $clog2(M * M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [M*M];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < M * M; k++) mem_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < M * M; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Callers only present in-range addresses.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/matrix_operand_server.sv
// Operand/result memory and host sequencer for the sequential matrix multiplier:
// streams A/B in, serves indexed operand reads, captures z beats into R, drains R.
module matrix_operand_server
  import matrix_operand_server_pkg::*;
#(
  parameter int M     = 4,
  parameter int IDX_W = idx_w(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              go,
  output logic              busy,
  output logic              mm_start,
  input  logic              mm_done,
  input  logic [IDX_W-1:0]  a_i,
  input  logic [IDX_W-1:0]  a_j,
  input  logic [IDX_W-1:0]  b_i,
  input  logic [IDX_W-1:0]  b_j,
  output logic [WORD_W-1:0] a_in,
  output logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] z_out,
  input  logic [IDX_W-1:0]  z_i,
  input  logic [IDX_W-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last
);

  localparam int NW = M * M;
  localparam int AW = $clog2(NW);
  localparam logic [AW-1:0] LAST = AW'(NW - 1);

  state_e        state_q;
  logic [AW-1:0] a_ptr_q, b_ptr_q, rd_ptr_q;
  logic [AW-1:0] a_ptr_d, b_ptr_d, rd_ptr_d;
  logic          a_full_q, b_full_q, ack_pend_q, run_first_q;
  logic          ld_ready_q, busy_q, mm_start_q, z_ack_q, rd_valid_q, rd_last_q;

  logic          ld_acc, go_acc, z_acc, done_acc, rd_xfer;
  logic          a_ok, b_ok, z_ok;
  logic [AW-1:0] a_addr, b_addr, z_addr;
  logic [WORD_W-1:0] a_rd, b_rd, r_rd;

  assign ld_acc   = (state_q == S_LOAD) && ld_valid;
  assign go_acc   = (state_q == S_LOAD) && go && a_full_q && b_full_q;
  assign z_acc    = (state_q == S_RUN) && z_stb && !ack_pend_q;
  // The first run cycle may still see mm_done left high by the previous run.
  assign done_acc = (state_q == S_RUN) && mm_done && !run_first_q;
  assign rd_xfer  = rd_valid_q && rd_ready;

  assign a_ptr_d  = (a_ptr_q == LAST) ? '0 : a_ptr_q + 1'b1;
  assign b_ptr_d  = (b_ptr_q == LAST) ? '0 : b_ptr_q + 1'b1;
  assign rd_ptr_d = rd_ptr_q + 1'b1;

  assign a_ok   = idx_ok(int'(a_i), int'(a_j), M);
  assign b_ok   = idx_ok(int'(b_i), int'(b_j), M);
  assign z_ok   = idx_ok(int'(z_i), int'(z_j), M);
  assign a_addr = a_ok ? AW'(rm_addr(int'(a_i), int'(a_j), M)) : '0;
  assign b_addr = b_ok ? AW'(rm_addr(int'(b_i), int'(b_j), M)) : '0;
  assign z_addr = z_ok ? AW'(rm_addr(int'(z_i), int'(z_j), M)) : '0;

  matrix_regfile #(.M(M), .AW(AW)) u_mat_a (
    .clk(clk), .rst(rst), .clr_i(1'b0),
    .we_i(ld_acc && !ld_sel), .waddr_i(a_ptr_q), .wdata_i(ld_data),
    .raddr_i(a_addr), .rdata_o(a_rd)
  );

  matrix_regfile #(.M(M), .AW(AW)) u_mat_b (
    .clk(clk), .rst(rst), .clr_i(1'b0),
    .we_i(ld_acc && ld_sel), .waddr_i(b_ptr_q), .wdata_i(ld_data),
    .raddr_i(b_addr), .rdata_o(b_rd)
  );

  // Out-of-range result beats are still acked but never written.
  matrix_regfile #(.M(M), .AW(AW)) u_mat_r (
    .clk(clk), .rst(rst), .clr_i(go_acc),
    .we_i(z_acc && z_ok), .waddr_i(z_addr), .wdata_i(z_out),
    .raddr_i(rd_ptr_q), .rdata_o(r_rd)
  );

  assign a_in     = a_ok ? a_rd : '0;
  assign b_in     = b_ok ? b_rd : '0;
  assign rd_data  = r_rd;
  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign z_ack    = z_ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      rd_ptr_q    <= '0;
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      ack_pend_q  <= 1'b0;
      run_first_q <= 1'b0;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mm_start_q  <= 1'b0;
      z_ack_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      z_ack_q <= z_acc;
      // One ack per z_stb assertion: re-arm only once the strobe drops.
      if (!z_stb)     ack_pend_q <= 1'b0;
      else if (z_acc) ack_pend_q <= 1'b1;

      case (state_q)
        S_LOAD: begin
          if (ld_acc && !ld_sel) begin
            a_ptr_q <= a_ptr_d;
            if (a_ptr_q == LAST) a_full_q <= 1'b1;
          end
          if (ld_acc && ld_sel) begin
            b_ptr_q <= b_ptr_d;
            if (b_ptr_q == LAST) b_full_q <= 1'b1;
          end
          if (go_acc) begin
            state_q    <= S_START;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            mm_start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q     <= S_RUN;
          mm_start_q  <= 1'b0;
          run_first_q <= 1'b1;
        end
        S_RUN: begin
          run_first_q <= 1'b0;
          if (done_acc) begin
            state_q    <= S_DRAIN;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b1;
            rd_last_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (rd_xfer) begin
            if (rd_last_q) begin
              state_q    <= S_LOAD;
              rd_ptr_q   <= '0;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              ld_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              rd_ptr_q  <= rd_ptr_d;
              rd_last_q <= (rd_ptr_d == LAST);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_server.sv
// Randomized scoreboard bench for matrix_operand_server with a behavioural
// multiplier driving the operand/result interface.
module tb_matrix_operand_server;

  localparam int M     = 3;
  localparam int IDX_W = 2;
  localparam int NW    = M * M;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ld_valid, ld_ready, ld_sel, go, busy, mm_start, mm_done;
  logic [31:0] ld_data, a_in, b_in, z_out, rd_data;
  logic [IDX_W-1:0] a_i, a_j, b_i, b_j, z_i, z_j;
  logic z_stb, z_ack, rd_valid, rd_ready, rd_last;

  always #5 clk = ~clk;

  matrix_operand_server #(.M(M), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data),
    .go(go), .busy(busy), .mm_start(mm_start), .mm_done(mm_done),
    .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .a_in(a_in), .b_in(b_in),
    .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int last_ack_cyc = -1;
  logic prev_ack = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  // Reference model state
  logic [31:0] refA [NW];
  logic [31:0] refB [NW];
  logic [31:0] refR [NW];
  int pa, pb;
  bit afull, bfull;
  logic [31:0] exp_data_q [$];
  bit          exp_last_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NW; k++) begin
      refA[k] = '0; refB[k] = '0; refR[k] = '0;
    end
    pa = 0; pb = 0; afull = 0; bfull = 0;
  endtask

  task automatic model_load(input bit sel, input logic [31:0] d);
    if (!sel) begin
      refA[pa] = d; pa++;
      if (pa == NW) begin pa = 0; afull = 1; end
    end else begin
      refB[pb] = d; pb++;
      if (pb == NW) begin pb = 0; bfull = 1; end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: ack pulse shape, drain stability and drain scoreboard.
  always @(negedge clk) begin
    logic [31:0] ed;
    bit el;
    if (z_ack === 1'b1) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      chk1("z_ack_single_cycle", prev_ack, 1'b0);
    end
    prev_ack = z_ack;
    if (rd_valid && prev_stall) chk("rd_data_stable", rd_data, prev_data);
    if (rd_valid && rd_ready) begin
      if (exp_data_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got %h, no beat expected", rd_data);
      end else begin
        ed = exp_data_q.pop_front();
        el = exp_last_q.pop_front();
        chk("rd_data", rd_data, ed);
        chk1("rd_last", rd_last, el);
      end
    end
    prev_stall = rd_valid && !rd_ready;
    prev_data  = rd_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input bit sel, input logic [31:0] d);
    ld_valid = 1'b1; ld_sel = sel; ld_data = d;
    @(negedge clk);
    chk1("ld_ready_load", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    model_load(sel, d);
  endtask

  task automatic go_req(input bit with_load, output bit started);
    bit exp;
    logic [31:0] d;
    exp = afull && bfull;
    d = $urandom;
    go = 1'b1;
    if (with_load) begin ld_valid = 1'b1; ld_sel = 1'b0; ld_data = d; end
    tick();
    go = 1'b0; ld_valid = 1'b0;
    if (with_load) model_load(1'b0, d);
    @(negedge clk);
    chk1("mm_start_after_go", mm_start, exp);
    chk1("busy_after_go", busy, exp);
    if (exp) for (int k = 0; k < NW; k++) refR[k] = '0;
    started = exp;
    tick();
  endtask

  // First S_RUN cycle: stale mm_done and a stray load beat must both be ignored.
  task automatic run_prologue();
    mm_done = 1'b1;
    ld_valid = 1'b1; ld_sel = 1'($urandom_range(0, 1)); ld_data = $urandom;
    @(negedge clk);
    chk1("mm_start_one_cycle", mm_start, 1'b0);
    chk1("ld_ready_run", ld_ready, 1'b0);
    tick();
    mm_done = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk1("stale_done_ignored", rd_valid, 1'b0);
    chk1("busy_run", busy, 1'b1);
    tick();
  endtask

  task automatic z_beat(input int i, input int j, input logic [31:0] v,
                        input int hold, input bit done);
    int c0, n0;
    if (i < M && j < M) refR[i*M + j] = v;
    if (done) begin
      for (int k = 0; k < NW; k++) begin
        exp_data_q.push_back(refR[k]);
        exp_last_q.push_back(k == NW - 1);
      end
    end
    z_i = IDX_W'(i); z_j = IDX_W'(j); z_out = v; z_stb = 1'b1; mm_done = done;
    c0 = cyc; n0 = ack_cnt;
    repeat (hold) @(posedge clk);
    #1;
    z_stb = 1'b0; mm_done = 1'b0;
    tick();
    chk("z_ack_count", ack_cnt - n0, 1);
    chk("z_ack_timing", last_ack_cyc, c0 + 1);
  endtask

  // Behavioural multiplier: reads operands, streams running partial sums.
  task automatic mult_run();
    logic [31:0] acc;
    bit last;
    a_i = IDX_W'(M); a_j = 0; b_i = 0; b_j = IDX_W'(M);
    #1;
    chk("a_in_out_of_range", a_in, 32'h0);
    chk("b_in_out_of_range", b_in, 32'h0);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        acc = '0;
        for (int k = 0; k < M; k++) begin
          a_i = IDX_W'(i); a_j = IDX_W'(k); b_i = IDX_W'(k); b_j = IDX_W'(j);
          #1;
          chk("a_in", a_in, refA[i*M + k]);
          chk("b_in", b_in, refB[k*M + j]);
          acc = acc + refA[i*M + k] * refB[k*M + j];
          last = (i == M-1) && (j == M-1) && (k == M-1);
          z_beat(i, j, acc, last ? 1 : $urandom_range(1, 3), last);
          if (!last && $urandom_range(0, 5) == 0)
            z_beat(M, $urandom_range(0, M-1), $urandom, 1, 1'b0);
        end
      end
    end
  endtask

  task automatic drain(input int mode);
    bit got;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n % 4 == 0) || (n % 4 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rd_valid && rd_ready && rd_last) got = 1;
      tick();
    end
    rd_ready = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL drain_timeout: rd_last transfer not seen in 200 cycles");
    end
    @(negedge clk);
    chk1("busy_after_drain", busy, 1'b0);
    chk1("rd_valid_after_drain", rd_valid, 1'b0);
    chk1("ld_ready_after_drain", ld_ready, 1'b1);
    tick();
  endtask

  logic [31:0] bfl [NW] = '{32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000,
                            32'h41000000, 32'h41100000, 32'h41200000};

  initial begin
    bit st;
    int n0;
    ld_valid = 0; ld_sel = 0; ld_data = '0; go = 0; mm_done = 0;
    a_i = '0; a_j = '0; b_i = '0; b_j = '0; z_i = '0; z_j = '0;
    z_out = '0; z_stb = 0; rd_ready = 0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_ld_ready", ld_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_mm_start", mm_start, 1'b0);
    chk1("reset_z_ack", z_ack, 1'b0);
    chk1("reset_rd_valid", rd_valid, 1'b0);
    chk1("reset_rd_last", rd_last, 1'b0);
    rst = 1'b1;
    tick();
    a_i = 2'd1; a_j = 2'd1; b_i = 2'd2; b_j = 2'd0;
    #1;
    chk("reset_a_zero", a_in, 32'h0);
    chk("reset_b_zero", b_in, 32'h0);

    // A = identity only: go must be ignored.
    for (int k = 0; k < NW; k++) load_word(1'b0, (k / M == k % M) ? 32'd1 : 32'd0);
    go_req(1'b0, st);

    n0 = ack_cnt;
    z_i = '0; z_j = '0; z_out = 32'h55; z_stb = 1'b1;
    repeat (2) tick();
    z_stb = 1'b0;
    tick();
    chk("no_ack_outside_run", ack_cnt - n0, 0);

    for (int k = 0; k < NW; k++) load_word(1'b1, bfl[k]);
    a_i = 2'd1; a_j = 2'd0; b_i = 2'd0; b_j = 2'd1;
    #1;
    chk("a_in_1_0", a_in, 32'd0);
    chk("b_in_0_1", b_in, 32'h40400000);
    a_j = 2'd1; b_i = 2'd3;
    #1;
    chk("a_in_1_1", a_in, 32'd1);
    chk("b_in_idx3", b_in, 32'h0);

    // Run 1: A = I, result equals B bit-exact.
    go_req(1'b0, st);
    if (st) begin run_prologue(); mult_run(); drain(0); end

    // Run 2: go without reload; directed handshake and R clearing.
    go_req(1'b0, st);
    if (st) begin
      run_prologue();
      z_beat(0, 1, 32'h40A00000, 3, 1'b0);
      z_beat(0, 1, 32'h41300000, 1, 1'b0);
      z_beat(M, 0, 32'hDEADBEEF, 1, 1'b0);
      z_beat(2, 2, 32'h12345678, 1, 1'b1);
      drain(1);
    end

    // Run 3: random operands, load beat concurrent with go.
    for (int k = 0; k < NW; k++) load_word(1'b0, $urandom);
    for (int k = 0; k < NW; k++) load_word(1'b1, $urandom);
    go_req(1'b1, st);
    if (st) begin run_prologue(); mult_run(); drain(2); end

    // Reset mid-run with z_stb high.
    go_req(1'b0, st);
    if (st) begin
      run_prologue();
      z_i = '0; z_j = '0; z_out = 32'hCAFEF00D; z_stb = 1'b1;
      @(posedge clk);
      #2;
      chk1("z_ack_before_reset", z_ack, 1'b1);
      rst = 1'b0;
      #1;
      chk1("reset_run_z_ack", z_ack, 1'b0);
      chk1("reset_run_busy", busy, 1'b0);
      chk1("reset_run_ld_ready", ld_ready, 1'b1);
      z_stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick();
    end
    go_req(1'b0, st);
    a_i = 2'd0; a_j = 2'd0; b_i = 2'd1; b_j = 2'd2;
    #1;
    chk("post_reset_a_zero", a_in, 32'h0);
    chk("post_reset_b_zero", b_in, 32'h0);
    for (int k = 0; k < NW; k++) load_word(1'b0, $urandom);
    go_req(1'b0, st);
    for (int k = 0; k < NW; k++) load_word(1'b1, $urandom);
    go_req(1'b0, st);
    if (st) begin run_prologue(); mult_run(); drain(2); end

    chk("drain_queue_empty", exp_data_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
